// File: rtl/alu_issue_stage.sv
// alu_issue_stage: register-file issue and write-back stage wrapped around a combinational ALU.
// Optional macro ALU_ISSUE_FWD_EN: issue during WB with result/carry forwarding.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdData,
    input  logic              InValid,
    output logic              InReady,
    input  logic [2:0]        Op,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    input  logic              UseCarry,
    output logic [DATA_W-1:0] ALU_In1,
    output logic [DATA_W-1:0] ALU_In2,
    output logic              ALU_CI,
    output logic [2:0]        ALU_A,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic              ALU_CO,
    output logic              OutValid,
    output logic [DATA_W-1:0] Result,
    output logic              CarryFlag
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [2:0] OP_ADD = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [ADDR_W-1:0] rd_q;

    logic              accept;
    logic              is_idle;
    logic              is_wb;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              cflag_src;
    logic              cin;

    assign is_idle = (state == IDLE);
    assign is_wb   = (state == WB);
    assign accept  = InValid & InReady;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        InReady  = 1'b0;
        OutValid = 1'b0;
        unique case (state)
            IDLE: begin
                InReady = ~LdEn;
                if (InValid && !LdEn) begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                state_n = WB;
            end
            WB: begin
                OutValid = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
                InReady = ~LdEn;
                state_n = (InValid && !LdEn) ? EXEC : IDLE;
`else
                state_n = IDLE;
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand and carry sources; in the forwarding build an op issued in WB
    // sees the in-flight result before it lands in the register file.
    always_comb begin
        src1      = rf[Rs1];
        src2      = rf[Rs2];
        cflag_src = CarryFlag;
`ifdef ALU_ISSUE_FWD_EN
        if (is_wb) begin
            if (Rs1 == rd_q) begin
                src1 = ALU_Out;
            end
            if (Rs2 == rd_q) begin
                src2 = ALU_Out;
            end
            if (ALU_A == OP_ADD) begin
                cflag_src = ALU_CO;
            end
        end
`endif
        cin = (Op == OP_ADD && UseCarry) ? cflag_src : 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_In1   <= '0;
            ALU_In2   <= '0;
            ALU_CI    <= 1'b0;
            ALU_A     <= 3'd0;
            rd_q      <= '0;
            Result    <= '0;
            CarryFlag <= 1'b0;
        end else begin
            if (is_wb) begin
                Result <= ALU_Out;
                if (ALU_A == OP_ADD) begin
                    CarryFlag <= ALU_CO;
                end
            end
            if (accept) begin
                ALU_In1 <= src1;
                ALU_In2 <= src2;
                ALU_CI  <= cin;
                ALU_A   <= Op;
                rd_q    <= Rd;
            end
        end
    end

    // Host loads only land in IDLE; write-back only in WB, so they never collide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (is_idle && LdEn) begin
                rf[LdAddr] <= LdData;
            end
            if (is_wb) begin
                rf[rd_q] <= ALU_Out;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized bench for alu_issue_stage with an ALU model
// and an architectural register/carry reference model.
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LdEn = 1'b0;
    logic [2:0]  LdAddr = '0;
    logic [31:0] LdData = '0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [2:0]  Op = '0;
    logic [2:0]  Rd = '0;
    logic [2:0]  Rs1 = '0;
    logic [2:0]  Rs2 = '0;
    logic        UseCarry = 1'b0;
    logic [31:0] ALU_In1;
    logic [31:0] ALU_In2;
    logic        ALU_CI;
    logic [2:0]  ALU_A;
    logic [31:0] ALU_Out;
    logic        ALU_CO;
    logic        OutValid;
    logic [31:0] Result;
    logic        CarryFlag;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mreg [8];
    logic        mc;

    alu_issue_stage #(.DATA_W(32), .ADDR_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
        .InValid(InValid), .InReady(InReady),
        .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .UseCarry(UseCarry),
        .ALU_In1(ALU_In1), .ALU_In2(ALU_In2), .ALU_CI(ALU_CI), .ALU_A(ALU_A),
        .ALU_Out(ALU_Out), .ALU_CO(ALU_CO),
        .OutValid(OutValid), .Result(Result), .CarryFlag(CarryFlag)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU: {carry-out, result}
    function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic [2:0] op);
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, a ^ b};
            3'd3: return {1'b0, ~a};
            3'd4: return {1'b0, a} + {1'b0, b} + {32'd0, ci};
            3'd5: return {a[31], a << b[4:0]};
            3'd6: return {a[0], a >> b[4:0]};
            default: return {1'b1, 16'h0, a[15:0]};
        endcase
    endfunction

    assign {ALU_CO, ALU_Out} = alu_f(ALU_In1, ALU_In2, ALU_CI, ALU_A);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [2:0] a, input logic [31:0] d);
        LdEn = 1'b1;
        LdAddr = a;
        LdData = d;
        #1;
        chk("ld_inready", 32'(InReady), 32'd0);
        tick();
        LdEn = 1'b0;
        mreg[a] = d;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic uc, input logic noise);
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [32:0] r;
        logic        exp_c;
        int          n;
        a = mreg[rs1];
        b = mreg[rs2];
        ci = (op == 3'd4 && uc) ? mc : 1'b0;
        r = alu_f(a, b, ci, op);
        exp_c = (op == 3'd4) ? r[32] : mc;
        Op = op;
        Rd = rd;
        Rs1 = rs1;
        Rs2 = rs2;
        UseCarry = uc;
        InValid = 1'b1;
        #1;
        n = 0;
        while (!InReady && n < 10) begin
            tick();
            n++;
        end
        chk("op_inready", 32'(InReady), 32'd1);
        tick();
        InValid = 1'b0;
        Op = 3'($urandom);
        Rs1 = 3'($urandom);
        Rs2 = 3'($urandom);
        if (noise) begin
            LdEn = 1'b1;
            LdAddr = 3'($urandom);
            LdData = $urandom;
        end
        #1;
        chk("exec_in1", ALU_In1, a);
        chk("exec_in2", ALU_In2, b);
        chk("exec_ci", 32'(ALU_CI), 32'(ci));
        chk("exec_op", 32'(ALU_A), 32'(op));
        chk("exec_outvalid", 32'(OutValid), 32'd0);
        chk("exec_inready", 32'(InReady), 32'd0);
        tick();
        chk("wb_outvalid", 32'(OutValid), 32'd1);
`ifdef ALU_ISSUE_FWD_EN
        chk("wb_inready", 32'(InReady), 32'(~LdEn));
`else
        chk("wb_inready", 32'(InReady), 32'd0);
`endif
        tick();
        LdEn = 1'b0;
        #1;
        chk("idle_outvalid", 32'(OutValid), 32'd0);
        chk("result", Result, r[31:0]);
        chk("carry", 32'(CarryFlag), 32'(exp_c));
        mreg[rd] = r[31:0];
        mc = exp_c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        mc = 1'b0;

        #1;
        chk("rst_in1", ALU_In1, 32'd0);
        chk("rst_in2", ALU_In2, 32'd0);
        chk("rst_ci", 32'(ALU_CI), 32'd0);
        chk("rst_op", 32'(ALU_A), 32'd0);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_carry", 32'(CarryFlag), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("post_rst_inready", 32'(InReady), 32'd1);
        tick();

        // Set carry and a nonzero destination, then reset in the middle of EXEC
        do_load(3'd1, 32'hFFFF_FFFF);
        do_load(3'd2, 32'h0000_0001);
        do_op(3'd4, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0);
        chk("add_res", Result, 32'h0);
        chk("add_carry", 32'(CarryFlag), 32'd1);
        Op = 3'd4; Rd = 3'd7; Rs1 = 3'd1; Rs2 = 3'd1; UseCarry = 1'b1; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_in1", ALU_In1, 32'd0);
        chk("mid_rst_op", 32'(ALU_A), 32'd0);
        chk("mid_rst_carry", 32'(CarryFlag), 32'd0);
        chk("mid_rst_result", Result, 32'd0);
        chk("mid_rst_outvalid", 32'(OutValid), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        mc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_no_wb", 32'(OutValid), 32'd0);
        end
        do_op(3'd1, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0);
        chk("mid_rst_r7", Result, 32'd0);

        // Directed functional cases
        do_load(3'd1, 32'h0000_00FF);
        do_load(3'd2, 32'h0F0F_0F0F);
        do_op(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0);
        chk("and_res", Result, 32'h0000_000F);
        do_op(3'd1, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0);
        chk("and_r3", Result, 32'h0000_000F);

        do_load(3'd1, 32'hFFFF_FFFF);
        do_load(3'd2, 32'h0000_0001);
        do_op(3'd4, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0);
        chk("add_wrap", Result, 32'h0);
        chk("add_wrap_c", 32'(CarryFlag), 32'd1);
        do_op(3'd4, 3'd5, 3'd2, 3'd2, 1'b1, 1'b0);
        chk("addc_res", Result, 32'h3);
        chk("addc_c", 32'(CarryFlag), 32'd0);
        do_op(3'd4, 3'd6, 3'd1, 3'd1, 1'b0, 1'b0);

        // Load and request in the same IDLE cycle: load wins
        LdEn = 1'b1; LdAddr = 3'd1; LdData = 32'hDEAD_BEEF;
        InValid = 1'b1; Op = 3'd1; Rd = 3'd3; Rs1 = 3'd1; Rs2 = 3'd1;
        #1;
        chk("ld_vs_op_inready", 32'(InReady), 32'd0);
        tick();
        LdEn = 1'b0;
        InValid = 1'b0;
        mreg[1] = 32'hDEAD_BEEF;
        #1;
        chk("ld_vs_op_idle", 32'(InReady), 32'd1);
        do_op(3'd1, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("ld_vs_op_res", Result, 32'hDEAD_BEEF);

        do_load(3'd1, 32'hA5A5_A5A5);
        do_op(3'd2, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("xor_self", Result, 32'h0);
        do_op(3'd3, 3'd2, 3'd1, 3'd5, 1'b0, 1'b0);
        chk("not_res", Result, 32'hFFFF_FFFF);
        chk("not_carry_kept", 32'(CarryFlag), 32'd1);

`ifdef ALU_ISSUE_FWD_EN
        do_load(3'd1, 32'd5);
        do_load(3'd2, 32'd3);
        Op = 3'd4; Rd = 3'd3; Rs1 = 3'd1; Rs2 = 3'd2; UseCarry = 1'b0; InValid = 1'b1;
        tick();
        Rd = 3'd4; Rs1 = 3'd3; Rs2 = 3'd3;
        tick();
        chk("fwd_wb1", 32'(OutValid), 32'd1);
        chk("fwd_wb_ready", 32'(InReady), 32'd1);
        tick();
        InValid = 1'b0;
        #1;
        chk("fwd_in1", ALU_In1, 32'd8);
        chk("fwd_in2", ALU_In2, 32'd8);
        tick();
        chk("fwd_wb2", 32'(OutValid), 32'd1);
        tick();
        chk("fwd_res", Result, 32'd16);
        mreg[3] = 32'd8;
        mreg[4] = 32'd16;
        mc = 1'b0;
`endif

        // Randomized mix against the reference model
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load(3'($urandom), ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom);
            end else begin
                do_op(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                      1'($urandom), 1'($urandom));
            end
        end

        for (int i = 0; i < 8; i++) begin
            do_op(3'd1, 3'(i), 3'(i), 3'(i), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
